// File: rtl/mips_instr_loader_pkg.sv
// Shared ISA definitions for the instruction loader: format codes, the opcode/funct
// set the control unit decodes, loader state encoding and legality helpers.
package mips_instr_loader_pkg;

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_J = 2'd2;
  localparam logic [1:0] FMT_X = 2'd3;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  function automatic logic r_funct_ok(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_JR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLTU: r_funct_ok = 1'b1;
      default:                                r_funct_ok = 1'b0;
    endcase
  endfunction

  function automatic logic i_op_ok(input logic [5:0] op);
    case (op)
      OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
      OP_LUI, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: i_op_ok = 1'b1;
      default:                                            i_op_ok = 1'b0;
    endcase
  endfunction

  function automatic logic j_op_ok(input logic [5:0] op);
    j_op_ok = (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational packer: field-level record in, 32-bit MIPS word plus legal flag out.
module mips_instr_pack
  import mips_instr_loader_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = 32'd0;
    legal = 1'b0;
    case (fmt)
      FMT_R: begin
        word  = {op, rs, rt, rd, shamt, funct};
        legal = (op == OP_SPECIAL) && r_funct_ok(funct);
      end
      FMT_I: begin
        word  = {op, rs, rt, imm};
        legal = i_op_ok(op);
      end
      FMT_J: begin
        word  = {op, target};
        legal = j_op_ok(op);
      end
      default: begin
        word  = 32'd0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_instr_loader.sv
// Instruction-memory writer: takes records over a valid/ready stream, validates and
// packs them, and writes them to consecutive word addresses from a start point.
module mips_instr_loader
  import mips_instr_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  err_idx,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output state_e            dbg_state
);

  // Handshake: a record transfers on a rising edge where in_valid and in_ready are
  // both high; in_ready is registered and high exactly while in LOAD, and does not
  // depend on in_valid.
  state_e            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  total;
  logic [31:0]       pack_word;
  logic              pack_legal;
  logic              hs;

  mips_instr_pack u_pack (
    .fmt    (in_fmt),
    .op     (in_op),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .shamt  (in_shamt),
    .funct  (in_funct),
    .imm    (in_imm),
    .target (in_target),
    .word   (pack_word),
    .legal  (pack_legal)
  );

  assign hs        = in_valid & in_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_idx   <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ptr    <= '0;
      remaining <= '0;
      total     <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE, ST_ERR: begin
          if (start) begin
            err     <= 1'b0;
            err_idx <= '0;
            if (count != '0) begin
              state     <= ST_LOAD;
              busy      <= 1'b1;
              in_ready  <= 1'b1;
              wr_ptr    <= base_addr;
              remaining <= count;
              total     <= count;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (hs) begin
            if (pack_legal) begin
              mem_we    <= 1'b1;
              mem_addr  <= wr_ptr;
              mem_wdata <= pack_word;
              wr_ptr    <= wr_ptr + ADDR_W'(1);
              remaining <= remaining - CNT_W'(1);
              if (remaining == CNT_W'(1)) begin
                state    <= ST_DONE;
                done     <= 1'b1;
                busy     <= 1'b0;
                in_ready <= 1'b0;
              end
            end else begin
              // The offending record is dropped; its index counts from the session start.
              err      <= 1'b1;
              err_idx  <= total - remaining;
              state    <= ST_ERR;
              busy     <= 1'b0;
              in_ready <= 1'b0;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_loader.sv
// Directed bench for mips_instr_loader: per-feature tasks with hand-computed words.
module tb_mips_instr_loader;
  import mips_instr_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  count = '0;
  logic        busy, done, err, in_ready, mem_we;
  logic [8:0]  err_idx;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        in_valid = 1'b0;
  logic [1:0]  in_fmt = '0;
  logic [5:0]  in_op = '0, in_funct = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  state_e      dbg_state;

  int n_vec = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [39:0] obs_q[$];
  logic [39:0] exp_q[$];

  mips_instr_loader #(.ADDR_W(8), .CNT_W(9)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .err(err), .err_idx(err_idx),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // write and done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset_n && mem_we) obs_q.push_back({mem_addr, mem_wdata});
    if (reset_n && done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rec(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                         input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt);
    in_fmt = f; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_funct = fn; in_imm = imm; in_target = tgt;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] c);
    start = 1'b1; base_addr = b; count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    n_vec++;
    if ({busy, done, err, err_idx, in_ready, mem_we, mem_addr, mem_wdata} !== 54'd0
        || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b idx=%0d rdy=%b we=%b a=%h d=%h st=%0d, want all 0 / IDLE",
               busy, done, err, err_idx, in_ready, mem_we, mem_addr, mem_wdata, dbg_state);
    end
    reset_n = 1'b1;
    tick();
    n_vec++;
    if ({busy, in_ready, mem_we, dbg_state} !== {3'b000, ST_IDLE}) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b rdy=%b we=%b st=%0d, want 0 0 0 IDLE", busy, in_ready, mem_we, dbg_state);
    end
  endtask

  task automatic test_r_type();
    do_start(8'h10, 9'd1);
    n_vec++;
    if ({busy, in_ready, dbg_state} !== {2'b11, ST_LOAD}) begin
      n_fail++;
      $display("FAIL r_enter_load: got busy=%b rdy=%b st=%0d, want 1 1 LOAD", busy, in_ready, dbg_state);
    end
    set_rec(FMT_R, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if ({mem_we, mem_addr, mem_wdata, done, busy} !== {1'b1, 8'h10, 32'h00221820, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL r_write: got we=%b a=%h d=%h done=%b busy=%b, want 1 10 00221820 1 0",
               mem_we, mem_addr, mem_wdata, done, busy);
    end
    tick();
    n_vec++;
    if ({mem_we, done, busy, dbg_state} !== {3'b000, ST_IDLE}) begin
      n_fail++;
      $display("FAIL r_after: got we=%b done=%b busy=%b st=%0d, want 0 0 0 IDLE", mem_we, done, busy, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w[3];
    exp_w[0] = 32'h8C220004; exp_w[1] = 32'h1022FFFF; exp_w[2] = 32'h08000010;
    do_start(8'h00, 9'd3);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_rec(FMT_I, OP_LW,  5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0);
        1: set_rec(FMT_I, OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0);
        default: set_rec(FMT_J, OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000010);
      endcase
      in_valid = 1'b1;
      tick();
      n_vec++;
      if ({mem_we, mem_addr, mem_wdata, done} !== {1'b1, 8'(i), exp_w[i], (i == 2)}) begin
        n_fail++;
        $display("FAIL b2b_write%0d: got we=%b a=%h d=%h done=%b, want 1 %h %h %b",
                 i, mem_we, mem_addr, mem_wdata, done, 8'(i), exp_w[i], (i == 2));
      end
    end
    in_valid = 1'b0;
    tick();
    n_vec++;
    if ({mem_we, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_tail: got we=%b done=%b, want 0 0", mem_we, done);
    end
  endtask

  task automatic test_illegal();
    do_start(8'h20, 9'd3);
    set_rec(FMT_R, 6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h21, 16'h0, 26'h0);
    in_valid = 1'b1;
    tick();
    n_vec++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h20, 32'h00853021}) begin
      n_fail++;
      $display("FAIL ill_first: got we=%b a=%h d=%h, want 1 20 00853021", mem_we, mem_addr, mem_wdata);
    end
    set_rec(FMT_R, 6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h3F, 16'h0, 26'h0);
    tick();
    n_vec++;
    if ({mem_we, err, err_idx, in_ready, busy, dbg_state} !== {2'b01, 9'd1, 2'b00, ST_ERR}) begin
      n_fail++;
      $display("FAIL ill_flag: got we=%b err=%b idx=%0d rdy=%b busy=%b st=%0d, want 0 1 1 0 0 ERR",
               mem_we, err, err_idx, in_ready, busy, dbg_state);
    end
    tick();
    n_vec++;
    if ({mem_we, err, dbg_state} !== {2'b01, ST_ERR}) begin
      n_fail++;
      $display("FAIL ill_sticky: got we=%b err=%b st=%0d, want 0 1 ERR", mem_we, err, dbg_state);
    end
    in_valid = 1'b0;
    do_start(8'h30, 9'd1);
    n_vec++;
    if ({err, err_idx, busy, dbg_state} !== {1'b0, 9'd0, 1'b1, ST_LOAD}) begin
      n_fail++;
      $display("FAIL ill_restart: got err=%b idx=%0d busy=%b st=%0d, want 0 0 1 LOAD", err, err_idx, busy, dbg_state);
    end
    set_rec(FMT_J, OP_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3FFFFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if ({mem_we, mem_addr, mem_wdata, done} !== {1'b1, 8'h30, 32'h0FFFFFFF, 1'b1}) begin
      n_fail++;
      $display("FAIL ill_reload: got we=%b a=%h d=%h done=%b, want 1 30 0fffffff 1", mem_we, mem_addr, mem_wdata, done);
    end
    tick();
  endtask

  task automatic test_count_zero();
    do_start(8'h40, 9'd0);
    n_vec++;
    if ({done, mem_we, busy, dbg_state} !== {3'b100, ST_DONE}) begin
      n_fail++;
      $display("FAIL zero_done: got done=%b we=%b busy=%b st=%0d, want 1 0 0 DONE", done, mem_we, busy, dbg_state);
    end
    tick();
    n_vec++;
    if ({done, mem_we, dbg_state} !== {2'b00, ST_IDLE}) begin
      n_fail++;
      $display("FAIL zero_after: got done=%b we=%b st=%0d, want 0 0 IDLE", done, mem_we, dbg_state);
    end
  endtask

  task automatic test_wrap();
    do_start(8'hFF, 9'd2);
    set_rec(FMT_I, OP_ORI, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0);
    in_valid = 1'b1;
    tick();
    n_vec++;
    if ({mem_we, mem_addr, mem_wdata, done} !== {1'b1, 8'hFF, 32'h34011234, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_ff: got we=%b a=%h d=%h done=%b, want 1 ff 34011234 0", mem_we, mem_addr, mem_wdata, done);
    end
    set_rec(FMT_I, OP_SW, 5'd29, 5'd31, 5'd0, 5'd0, 6'h0, 16'h0008, 26'h0);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if ({mem_we, mem_addr, mem_wdata, done} !== {1'b1, 8'h00, 32'hAFBF0008, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_00: got we=%b a=%h d=%h done=%b, want 1 00 afbf0008 1", mem_we, mem_addr, mem_wdata, done);
    end
    tick();
  endtask

  task automatic test_ignored();
    do_start(8'h50, 9'd2);
    start = 1'b1; base_addr = 8'hA0; count = 9'd7;
    tick();
    start = 1'b0;
    n_vec++;
    if ({busy, mem_we, dbg_state} !== {2'b10, ST_LOAD}) begin
      n_fail++;
      $display("FAIL ign_start_load: got busy=%b we=%b st=%0d, want 1 0 LOAD", busy, mem_we, dbg_state);
    end
    set_rec(FMT_J, OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000123);
    in_valid = 1'b1;
    tick();
    n_vec++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h50, 32'h08000123}) begin
      n_fail++;
      $display("FAIL ign_w0: got we=%b a=%h d=%h, want 1 50 08000123", mem_we, mem_addr, mem_wdata);
    end
    set_rec(FMT_I, OP_SLTI, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'h8000, 26'h0);
    start = 1'b1; base_addr = 8'hB0; count = 9'd5;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if ({mem_we, mem_addr, mem_wdata, done} !== {1'b1, 8'h51, 32'h28438000, 1'b1}) begin
      n_fail++;
      $display("FAIL ign_w1: got we=%b a=%h d=%h done=%b, want 1 51 28438000 1", mem_we, mem_addr, mem_wdata, done);
    end
    tick();
    start = 1'b0;
    n_vec++;
    if ({busy, dbg_state} !== {1'b0, ST_IDLE}) begin
      n_fail++;
      $display("FAIL ign_start_done: got busy=%b st=%0d, want 0 IDLE", busy, dbg_state);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if ({mem_we, in_ready, dbg_state} !== {2'b00, ST_IDLE}) begin
      n_fail++;
      $display("FAIL ign_valid_idle: got we=%b rdy=%b st=%0d, want 0 0 IDLE", mem_we, in_ready, dbg_state);
    end
  endtask

  task automatic test_reset_abort();
    do_start(8'h60, 9'd2);
    set_rec(FMT_I, OP_ADDI, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pending: got we=%b, want 1", mem_we);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, err, err_idx, in_ready, mem_we, mem_addr, mem_wdata} !== 54'd0
        || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy=%b we=%b rdy=%b a=%h d=%h st=%0d, want all 0 / IDLE",
               busy, mem_we, in_ready, mem_addr, mem_wdata, dbg_state);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_stalls();
    int gap;
    obs_q.delete();
    exp_q.delete();
    done_cnt = 0;
    exp_q.push_back({8'h80, 32'h8C220004});
    exp_q.push_back({8'h81, 32'h1022FFFF});
    exp_q.push_back({8'h82, 32'h08000010});
    exp_q.push_back({8'h83, 32'h00221820});
    do_start(8'h80, 9'd4);
    for (int i = 0; i < 4; i++) begin
      gap = $urandom_range(0, 5);
      in_valid = 1'b0;
      repeat (gap) tick();
      case (i)
        0: set_rec(FMT_I, OP_LW,  5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0);
        1: set_rec(FMT_I, OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0);
        2: set_rec(FMT_J, OP_J,   5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000010);
        default: set_rec(FMT_R, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
      endcase
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (obs_q.size() !== exp_q.size() || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL stall_count: got writes=%0d dones=%0d, want %0d 1", obs_q.size(), done_cnt, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stall_write%0d: got %h, want %h", i, (i < obs_q.size()) ? obs_q[i] : 40'h0, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_back_to_back();
    test_illegal();
    test_count_zero();
    test_wrap();
    test_ignored();
    test_reset_abort();
    test_stalls();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
